// File: rtl/wb_initiator_seq.sv
// Wishbone classic initiator: one valid/ready command becomes one bus cycle and one response.
// Optional ack timeout is enabled by defining WB_INITIATOR_TIMEOUT_EN.
module wb_initiator_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [AW-1:0]     cmd_adr_i,
  input  logic [DW-1:0]     cmd_dat_i,
  input  logic [DW/8-1:0]   cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [DW-1:0]     wbm_dat_i
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic [DW-1:0]     rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  // Last un-acked BUS cycle is the one where the count is about to reach TIMEOUT_CYCLES.
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q == StBus && !wbm_ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q == CntLast);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          state_d = StBus;
        end
      end
      StBus: begin
        // Ack takes priority over a coincident timeout.
        if (wbm_ack_i) begin
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          state_d   = StResp;
        end else if (timeout) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // cyc/stb decode straight from state so reset drops them asynchronously.
  assign cmd_ready_o = (state_q == StIdle);
  assign wbm_cyc_o   = (state_q == StBus);
  assign wbm_stb_o   = (state_q == StBus);
  assign rsp_valid_o = (state_q == StResp);
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_initiator_seq.sv
// Directed and randomized bench for wb_initiator_seq against a small memory-backed slave model.
// Timeout scenarios are compiled in when WB_INITIATOR_TIMEOUT_EN is defined.
module tb_wb_initiator_seq;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam int unsigned T     = 8;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned T     = 255;
  localparam bit          TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic        ack = 1'b0;
  logic [31:0] dat_i = '0;

  int checks = 0;
  int errors = 0;

  // ref_mem follows the commands; slv_mem follows what the DUT actually puts on the bus.
  logic [31:0] ref_mem [8];
  logic [31:0] slv_mem [8];

  always #5 clk = ~clk;

  wb_initiator_seq #(
    .TIMEOUT_CYCLES(T),
    .AW(32),
    .DW(32)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .cmd_sel_i  (cmd_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat_o),
    .wbm_ack_i  (ack),
    .wbm_dat_i  (dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b+:8] = nw[8*b+:8];
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  // ack_at: stb cycle (1-based) on which the slave acks, <= 0 means never.
  task automatic run_txn(input logic we_c, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int ack_at, input int bp);
    int          n;
    int          exp_n;
    logic        exp_err;
    logic [31:0] exp_dat;
    exp_err = TO_EN && (ack_at <= 0 || ack_at > int'(T));
    exp_n   = exp_err ? int'(T) : ack_at;
    exp_dat = (we_c || exp_err) ? 32'h0 : ref_mem[a[4:2]];
    if (we_c && !exp_err) ref_mem[a[4:2]] = merge(ref_mem[a[4:2]], d, s);

    chk("idle_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we_c;
    cmd_adr   = a;
    cmd_dat   = d;
    cmd_sel   = s;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (cyc === 1'b1 && n < 400) begin
      n++;
      chk("stb", 32'(stb), 32'd1);
      chk("wbm_we", 32'(we), 32'(we_c));
      chk("wbm_adr", adr, a);
      chk("wbm_dat", dat_o, d);
      chk("wbm_sel", 32'(sel), 32'(s));
      chk("busy_ready", 32'(cmd_ready), 32'd0);
      dat_i = $urandom;
      if (n == ack_at) begin
        ack = 1'b1;
        if (we) slv_mem[adr[4:2]] = merge(slv_mem[adr[4:2]], dat_o, sel);
        else    dat_i = slv_mem[adr[4:2]];
      end else begin
        ack = 1'b0;
      end
      @(negedge clk);
    end
    ack = 1'b0;
    chk("stb_cycles", 32'(n), 32'(exp_n));
    chk("cyc_drop", 32'(cyc), 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));

    if (bp > 0) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_we    = 1'($urandom);
      cmd_adr   = $urandom;
      cmd_dat   = $urandom;
      cmd_sel   = 4'($urandom);
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_dat", rsp_dat, exp_dat);
        chk("bp_err", 32'(rsp_err), 32'(exp_err));
        chk("bp_ready", 32'(cmd_ready), 32'd0);
        chk("bp_adr_hold", adr, a);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic        rw;
    logic [31:0] v;
    int          idx;

    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      slv_mem[i] = v;
    end
    ref_mem[2] = 32'h1234_5678;
    slv_mem[2] = 32'h1234_5678;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdat", rsp_dat, 32'd0);
    chk("rst_adr", adr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait write, wait-state read, backpressured read of the written word
    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 0);
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 5, 0);
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, 10);

    // Stray ack while idle: nothing captured, no response
    ack   = 1'b1;
    dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    ack = 1'b0;
    chk("stray_valid", 32'(rsp_valid), 32'd0);
    chk("stray_ready", 32'(cmd_ready), 32'd1);
    chk("stray_cyc", 32'(cyc), 32'd0);
    chk("stray_dat", rsp_dat, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("stray_valid2", 32'(rsp_valid), 32'd0);

`ifdef WB_INITIATOR_TIMEOUT_EN
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, -1, 0);
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, int'(T), 0);
`endif

    // Reset during the third wait cycle abandons the transaction
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_000C;
    cmd_sel   = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_cyc", 32'(cyc), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(cyc), 32'd0);
    chk("mid_rst_stb", 32'(stb), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_cyc", 32'(cyc), 32'd0);
    end
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 0);

    // Randomized traffic against the memory model
    for (int k = 0; k < 24; k++) begin
      rw  = 1'($urandom);
      idx = $urandom_range(0, 7);
      run_txn(rw, 32'h3000_0000 | 32'(idx << 2), $urandom, 4'($urandom),
              $urandom_range(1, 4), $urandom_range(0, 2));
    end
    for (int i = 0; i < 8; i++) begin
      run_txn(1'b0, 32'h3000_0000 | 32'(i << 2), 32'h0, 4'hF, 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_initiator_seq.md
Name: wb_initiator_seq

Overview:
- Wishbone classic master. It is the initiator-side counterpart of the wbs_* slave interface that the user area exposes.
- Accepts single read/write commands over a valid/ready command port and runs one Wishbone cycle per command.
- Returns read data and completion status over a valid/ready response port.
- Used in the user area to drive on-chip Wishbone slaves (test peripherals, register banks) from LA- or IO-driven control logic.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a bus cycle may wait for ack before abort (timeout feature only). Legal range 1..65535.
- AW, 32: address width.
- DW, 32: data width; must be a multiple of 8.

Ports:
- wb_clk_i  in  1  single clock; all logic on rising edge
- wb_rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  AW  byte address
- cmd_dat_i  in  DW  write data
- cmd_sel_i  in  DW/8  byte selects
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_dat_o  out  DW  read data; 0 for writes and for timeouts
- rsp_err_o  out  1  1 = transaction timed out
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  DW/8  Wishbone byte selects
- wbm_adr_o  out  AW  Wishbone address
- wbm_dat_o  out  DW  Wishbone write data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_dat_i  in  DW  Wishbone read data

Behaviour:
- Reset (async assert on wb_rst_ni low, sync deassert):
  - state = IDLE
  - all outputs 0, except cmd_ready_o = 1
  - timeout counter = 0
- States: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, latch we/adr/dat/sel into the wbm_* registers and go to BUS.
  - wbm_cyc_o and wbm_stb_o rise together in the next cycle.
- BUS:
  - cmd_ready_o = 0. cyc, stb, we, sel, adr and dat are held stable.
  - On a cycle where wbm_ack_i = 1:
    - capture wbm_dat_i into rsp_dat_o (reads only; writes load 0)
    - rsp_err_o = 0
    - deassert cyc/stb next cycle, go to RESP
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o are held stable.
  - On rsp_ready_i, go to IDLE next cycle: rsp_valid_o = 0, cmd_ready_o = 1.
  - A new command is therefore accepted no earlier than the cycle after the handshake.
- Latency, with a zero-wait slave that acks in the first stb cycle:
  - command accept at cycle N
  - stb at N+1
  - rsp_valid_o at N+2
- Exactly one outstanding transaction. No pipelining, no bursts. cti/bte are not generated.
- wbm_ack_i outside BUS is ignored: no state change, no data capture.
- rsp_ready_i held high permanently: response lasts exactly one cycle.
- Reset mid-BUS: cyc/stb drop asynchronously and the transaction is discarded with no response. The slave must tolerate an abandoned cycle.
- Reset mid-RESP: the pending response is lost.
- wbm_dat_o, wbm_adr_o and wbm_sel_o keep their last values after the cycle ends; only cyc/stb return to 0.

Optional Feature:
- Macro: WB_INITIATOR_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with ack low, the cycle aborts: cyc/stb drop next cycle, go to RESP with rsp_err_o = 1 and rsp_dat_o = 0.
  - Ack and timeout in the same cycle: ack wins, rsp_err_o = 0.
- Undefined:
  - No counter; BUS waits indefinitely for ack.
  - rsp_err_o is tied 0.

Test Plan:
- Zero-wait write: cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF, slave acks immediately -> one stb cycle with those values, rsp_valid_o two cycles after accept, rsp_dat_o = 0, rsp_err_o = 0.
- Wait-state read: slave acks after 5 cycles with 0x1234_5678 -> cyc/stb high exactly 5 cycles, rsp_dat_o = 0x1234_5678, adr/sel stable throughout.
- Response backpressure: rsp_ready_i low for 10 cycles, cmd_valid_i held high -> rsp_valid_o and rsp_dat_o stable for 10 cycles, cmd_ready_o = 0 throughout, next command accepted the cycle after the handshake.
- Timeout (WB_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES = 8): slave never acks -> stb high 8 cycles then drops, rsp_err_o = 1, rsp_dat_o = 0. Second run with ack on the 8th cycle -> rsp_err_o = 0 with ack data.
- Stray ack: pulse wbm_ack_i with wbm_dat_i = 0xFFFF_FFFF while IDLE -> no rsp_valid_o, state stays IDLE.
- Reset mid-BUS: wb_rst_ni low during the 3rd wait cycle -> cyc/stb 0 immediately, no response after release, next command completes normally.
